fpu_normalize_round: RTL and testbench
======================================

Name: fpu_normalize_round

Overview:
Downstream stage of the FPU datapath. Takes the raw unnormalised product, quotient, sum or difference (sign, wide exponent, 106-bit mantissa) and produces a packed IEEE-754 double.
- Normalises with a leading-one shift.
- Rounds to nearest-even.
- Saturates overflow to infinity and flushes underflow to signed zero.
- Generates Z/N/C/O flags.
- Two-stage pipeline with valid/ready handshake; one result per cycle when not stalled.

Parameters:
MANT_W, 106, raw mantissa width
POINT, 104, bit index of the integer (hidden-1) position of a normalised value
EXP_IN_W, 13, signed biased input exponent width (two's complement)
FRAC_W, 52, output fraction width
EXP_W, 11, output exponent width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low
i_valid  in  1  upstream operand valid
o_ready  out  1  stage can accept
i_sign  in  1  result sign
i_exp  in  EXP_IN_W  signed biased exponent
i_mant  in  MANT_W  raw mantissa; value = i_mant/2^POINT * 2^(i_exp-1023)
i_gen_flags  in  1  capture flags for this item
o_valid  out  1  result valid
i_ready  in  1  downstream accepts
o_result  out  64  packed double
o_z, o_n, o_c, o_o  out  1 each  zero, negative, inexact, overflow

Behaviour:
- Reset (i_rst=0, async): o_valid=0, o_result=0, all flags 0, internal valids 0. Reset mid-operation drops in-flight items.
- Handshake:
  - Transfer in when i_valid & o_ready; out when o_valid & i_ready.
  - advance = !o_valid | i_ready.
  - o_ready = !s1_valid | advance, which is combinational from i_ready.
  - Outputs hold stable while o_valid & !i_ready.
- Latency: 2 cycles from accept to o_valid when unstalled.
- Stage 1 (registered on accept):
  - p = index of the leading one in i_mant.
  - Left-align so the leading one sits at POINT.
  - exp1 = i_exp + (p - POINT), computed at EXP_IN_W+1 bits.
  - i_mant==0 marks zero.
  - Bits shifted out to the right (when p > POINT) OR into sticky.
- Stage 2:
  - Fraction = bits POINT-1 .. POINT-52.
  - Guard = next bit; sticky = OR of all lower bits plus the stage-1 sticky.
  - Round up iff guard & (sticky | frac[0]).
  - Rounding carry out of the fraction: frac=0, exp1+1.
- Results:
  - exp ≥ 2047 → 0x7FF/frac 0 (signed infinity), o=1.
  - exp ≤ 0 → signed zero, exp 0/frac 0 (no subnormals), c=1 if the mantissa was nonzero.
  - Zero input → signed zero, c=0.
- Flags:
  - z = (exp==0 & frac==0).
  - n = sign & !z.
  - c = guard|sticky, or underflow flush.
  - o = overflow.
- Flag update rule: flags update only when the output item carried i_gen_flags=1; otherwise they hold their previous values. o_result always updates.
- Simultaneous accept and output on the same cycle is legal; no bubble, order preserved.

Decomposition:
- Shared package fpu_pkg holds:
  - the Float struct (sign/exponent/fraction);
  - the constants FPU_BIAS=1023, FPU_EXP_MAX=2047, FPU_FRAC_W=52;
  - the packed stage-1 payload typedef.
- One sub-module: fpu_lzc. It is a combinational 106-bit leading-one detector returning a 7-bit index plus a zero flag, and is reused by the FPU add path.

Test Plan:
- mant=1<<104, exp=1023, sign=0, gen_flags=1 → after 2 cycles o_result=0x3FF0000000000000, z=n=c=o=0.
- mant=1<<105, exp=1023 → 0x4000000000000000; mant=1<<60, exp=1067 → 0x3FF0000000000000.
- Rounding:
  - mant=(1<<104)|(1<<51) (tie, lsb 0) → 0x3FF0000000000000, c=1.
  - mant=(1<<104)|(1<<52)|(1<<51) → 0x3FF0000000000002.
  - mant bits 104..51 all ones → carry → 0x4000000000000000.
- Saturation and flush:
  - exp=2047, mant=1<<104 → 0x7FF0000000000000, o=1.
  - sign=1, exp=0 → 0x8000000000000000, z=1, n=0, c=1.
  - mant=0 → 0, z=1, c=0.
- Pipelining and flag gating:
  - 4 back-to-back items with i_ready held low 3 cycles → no loss, no duplication, in-order outputs, o_ready deasserts while both stages are full.
  - An item with gen_flags=0 leaves the flags unchanged.
- Reset: assert i_rst=0 with 2 items in flight → o_valid=0 immediately, no stale result after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU types and constants.
// Used by the normalise/round stage and the add path.
package fpu_pkg;

    localparam int MANT_W   = 106;
    localparam int POINT    = 104;
    localparam int EXP_IN_W = 13;
    localparam int FRAC_W   = 52;
    localparam int EXP_W    = 11;
    localparam int LZC_W    = 7;
    localparam int S1_EW    = EXP_IN_W + 1;

    localparam int FPU_BIAS    = 1023;
    localparam int FPU_EXP_MAX = 2047;
    localparam int FPU_FRAC_W  = 52;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [FRAC_W-1:0] frac;
    } float_t;

    // Aligned operand. The hidden one is implied by !zero,
    // so only the bits below POINT are carried.
    typedef struct packed {
        logic             sign;
        logic             zero;
        logic             gen_flags;
        logic             sticky;
        logic [S1_EW-1:0] exp;
        logic [POINT-1:0] mant;
    } s1_t;

endpackage

// File: rtl/fpu_lzc.sv
// Leading-one detector over the raw mantissa.
// Returns the bit index of the highest set bit.
module fpu_lzc
    import fpu_pkg::*;
(
    input  logic [MANT_W-1:0] a_i,
    output logic [LZC_W-1:0]  idx_o,
    output logic              zero_o
);

    // Priority scan: the last set bit seen wins.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < MANT_W; i++) begin
            if (a_i[i]) begin
                idx_o = LZC_W'(i);
            end
        end
    end

    assign zero_o = ~|a_i;

endmodule

// File: rtl/fpu_normalize_round.sv
// Normalise, round-to-nearest-even and pack a double.
// Two registered stages with valid/ready flow control.
module fpu_normalize_round
    import fpu_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_sign,
    input  logic [EXP_IN_W-1:0] i_exp,
    input  logic [MANT_W-1:0]   i_mant,
    input  logic                i_gen_flags,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [63:0]         o_result,
    output logic                o_z,
    output logic                o_n,
    output logic                o_c,
    output logic                o_o
);

    logic [LZC_W-1:0] lz_idx;
    logic             lz_zero;

    s1_t  s1_d;
    s1_t  s1_q;
    logic s1_valid_q;

    logic   out_valid_q;
    float_t res_d;
    float_t res_q;
    logic   z_d, n_d, c_d, o_d;
    logic   z_q, n_q, c_q, o_q;

    logic advance;

    logic [FRAC_W-1:0] frac;
    logic              guard;
    logic              sticky;
    logic              rnd;
    logic [FRAC_W:0]   frac_r;
    logic [S1_EW-1:0]  exp2;

    fpu_lzc u_lzc (
        .a_i    (i_mant),
        .idx_o  (lz_idx),
        .zero_o (lz_zero)
    );

    assign advance  = !out_valid_q || i_ready;
    assign o_ready  = !s1_valid_q || advance;
    assign o_valid  = out_valid_q;
    assign o_result = res_q;
    assign o_z      = z_q;
    assign o_n      = n_q;
    assign o_c      = c_q;
    assign o_o      = o_q;

    // Align the leading one to POINT and rebias the exponent.
    always_comb begin
        s1_d           = '0;
        s1_d.sign      = i_sign;
        s1_d.zero      = lz_zero;
        s1_d.gen_flags = i_gen_flags;
        s1_d.exp       = {i_exp[EXP_IN_W-1], i_exp}
                       + S1_EW'(lz_idx)
                       - S1_EW'(POINT);
        // Only one bit sits above POINT, so a right
        // shift is at most one place.
        if (lz_idx > LZC_W'(POINT)) begin
            s1_d.mant   = POINT'(i_mant >> 1);
            s1_d.sticky = i_mant[0];
        end else begin
            s1_d.mant = POINT'(i_mant << (LZC_W'(POINT) - lz_idx));
        end
    end

    // Round, then saturate or flush, and derive the flags.
    always_comb begin
        frac   = s1_q.mant[POINT-1 -: FRAC_W];
        guard  = s1_q.mant[POINT-1-FRAC_W];
        sticky = (|s1_q.mant[POINT-2-FRAC_W:0]) | s1_q.sticky;
        rnd    = guard & (sticky | frac[0]);
        frac_r = {1'b0, frac} + (FRAC_W+1)'(rnd);
        exp2   = s1_q.exp + S1_EW'(frac_r[FRAC_W]);

        res_d.sign = s1_q.sign;
        res_d.exp  = exp2[EXP_W-1:0];
        res_d.frac = frac_r[FRAC_W-1:0];
        c_d        = guard | sticky;
        o_d        = 1'b0;

        if (s1_q.zero) begin
            res_d.exp  = '0;
            res_d.frac = '0;
            c_d        = 1'b0;
        end else if (!exp2[S1_EW-1] &&
                     exp2 >= S1_EW'(FPU_EXP_MAX)) begin
            res_d.exp  = '1;
            res_d.frac = '0;
            o_d        = 1'b1;
        end else if (exp2[S1_EW-1] || exp2 == '0) begin
            res_d.exp  = '0;
            res_d.frac = '0;
            c_d        = 1'b1;
        end

        z_d = (res_d.exp == '0) && (res_d.frac == '0);
        n_d = res_d.sign & !z_d;
    end

    // Stage-1 register: take a new operand whenever the slot frees.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (o_ready) begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Output register: result always, flags only when requested.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            o_q         <= 1'b0;
        end else if (advance) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_q <= res_d;
                if (s1_q.gen_flags) begin
                    z_q <= z_d;
                    n_q <= n_d;
                    c_q <= c_d;
                    o_q <= o_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Directed bench for fpu_normalize_round.
// Hand-computed vectors, pipeline stall and reset cases.
module tb_fpu_normalize_round;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic         i_sign;
    logic [12:0]  i_exp;
    logic [105:0] i_mant;
    logic         i_gen_flags;
    logic         o_valid;
    logic         i_ready;
    logic [63:0]  o_result;
    logic         o_z, o_n, o_c, o_o;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [105:0] ONE  = 106'd1 << 104;
    localparam logic [105:0] ONES = ((106'd1 << 54) - 106'd1) << 51;

    fpu_normalize_round dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sign      (i_sign),
        .i_exp       (i_exp),
        .i_mant      (i_mant),
        .i_gen_flags (i_gen_flags),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_z         (o_z),
        .o_n         (o_n),
        .o_c         (o_c),
        .o_o         (o_o)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Send one item, wait for it, check result and {z,n,c,o}.
    task automatic run_vec(input string tag,
                           input logic s,
                           input logic [12:0] e,
                           input logic [105:0] m,
                           input logic gf,
                           input logic [63:0] er,
                           input logic [3:0] fl,
                           output int lat);
        @(negedge i_clk);
        i_ready     = 1'b1;
        i_valid     = 1'b1;
        i_sign      = s;
        i_exp       = e;
        i_mant      = m;
        i_gen_flags = gf;
        @(negedge i_clk);
        i_valid = 1'b0;
        lat = 1;
        while (!o_valid && lat < 10) begin
            @(negedge i_clk);
            lat++;
        end
        if (!o_valid) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_res"}, o_result, er);
            chk({tag, "_flags"}, 64'({o_z, o_n, o_c, o_o}),
                64'(fl));
        end
    endtask

    initial begin
        int lat;
        int sent, got, hold_bad, extra;
        logic seen_stall, stalled_prev;
        logic [63:0] held;
        logic [63:0] expq [4];

        i_rst       = 1'b0;
        i_valid     = 1'b0;
        i_ready     = 1'b1;
        i_sign      = 1'b0;
        i_exp       = '0;
        i_mant      = '0;
        i_gen_flags = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_result", o_result, 64'd0);
        chk("rst_flags", 64'({o_z, o_n, o_c, o_o}), 64'd0);
        i_rst = 1'b1;
        @(negedge i_clk);
        #1;
        chk("rst_ready", 64'(o_ready), 64'd1);

        run_vec("one", 0, 13'd1023, ONE, 1,
                64'h3FF0000000000000, 4'b0000, lat);
        chk("latency", 64'(lat), 64'd2);
        run_vec("two", 0, 13'd1023, 106'd1 << 105, 1,
                64'h4000000000000000, 4'b0000, lat);
        run_vec("shl", 0, 13'd1067, 106'd1 << 60, 1,
                64'h3FF0000000000000, 4'b0000, lat);
        run_vec("tie_even", 0, 13'd1023, ONE | (106'd1 << 51), 1,
                64'h3FF0000000000000, 4'b0010, lat);
        run_vec("tie_odd", 0, 13'd1023,
                ONE | (106'd1 << 52) | (106'd1 << 51), 1,
                64'h3FF0000000000002, 4'b0010, lat);
        run_vec("carry", 0, 13'd1023, ONES, 1,
                64'h4000000000000000, 4'b0010, lat);
        run_vec("neg", 1, 13'd1023, ONE, 1,
                64'hBFF0000000000000, 4'b0100, lat);
        run_vec("minnorm", 0, 13'd1, ONE, 1,
                64'h0010000000000000, 4'b0000, lat);
        run_vec("ovf", 0, 13'd2047, ONE, 1,
                64'h7FF0000000000000, 4'b0001, lat);
        run_vec("ovf_rnd", 0, 13'd2046, ONES, 1,
                64'h7FF0000000000000, 4'b0011, lat);
        run_vec("gated", 0, 13'd1023, ONE, 0,
                64'h3FF0000000000000, 4'b0011, lat);
        run_vec("flush", 1, 13'd0, ONE, 1,
                64'h8000000000000000, 4'b1010, lat);
        run_vec("flush_neg", 0, 13'h1F00, ONE, 1,
                64'h0000000000000000, 4'b1010, lat);
        run_vec("zero", 0, 13'd1023, 106'd0, 1,
                64'h0000000000000000, 4'b1000, lat);

        // Four back-to-back items, downstream stalled 3 cycles.
        for (int k = 0; k < 4; k++) begin
            expq[k] = 64'(1000 + k) << 52;
        end
        sent = 0;
        got = 0;
        hold_bad = 0;
        seen_stall = 1'b0;
        stalled_prev = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge i_clk);
            i_ready     = (cyc >= 3);
            i_valid     = (sent < 4);
            i_sign      = 1'b0;
            i_exp       = 13'(1000 + sent);
            i_mant      = ONE;
            i_gen_flags = 1'b1;
            #1;
            if (!o_ready) seen_stall = 1'b1;
            if (stalled_prev && o_result !== held) hold_bad++;
            stalled_prev = o_valid & !i_ready;
            held = o_result;
            if (o_valid && i_ready) begin
                if (got < 4) chk("pipe_res", o_result, expq[got]);
                got++;
            end
            if (i_valid && o_ready) sent++;
        end
        chk("pipe_count", 64'(got), 64'd4);
        chk("pipe_stall", 64'(seen_stall), 64'd1);
        chk("pipe_hold", 64'(hold_bad), 64'd0);
        @(negedge i_clk);
        i_valid = 1'b0;
        extra = 0;
        repeat (5) begin
            @(negedge i_clk);
            if (o_valid) extra++;
        end
        chk("pipe_dup", 64'(extra), 64'd0);

        // Two items in flight, then asynchronous reset.
        i_ready = 1'b0;
        repeat (2) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            i_exp   = 13'd1023;
            i_mant  = ONE;
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        #1;
        chk("inflight_valid", 64'(o_valid), 64'd1);
        #1;
        i_rst = 1'b0;
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_result", o_result, 64'd0);
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_ready = 1'b1;
        extra = 0;
        repeat (5) begin
            @(negedge i_clk);
            if (o_valid) extra++;
        end
        chk("arst_stale", 64'(extra), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
